// File: rtl/mmio_input_pkg.sv
// Register map and address decode shared by the DE2 switch/key input peripheral.
package mmio_input_pkg;

    localparam logic [1:0] SW_STATE_IDX  = 2'd0;
    localparam logic [1:0] KEY_STATE_IDX = 2'd1;
    localparam logic [1:0] KEY_EDGE_IDX  = 2'd2;
    localparam logic [1:0] IRQ_EN_IDX    = 2'd3;

    // Byte base address of the peripheral on the processor bus; the bus only
    // hands us the word index, so just its word-within-block bits matter here.
    localparam logic [31:0] MMIO_INPUT_BASE = 32'h0000_0000;
    localparam logic [1:0]  BASE_WORD       = MMIO_INPUT_BASE[3:2];

    function automatic logic [1:0] reg_index(input logic [1:0] addr);
        return addr - BASE_WORD;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// One-bit 2-flop synchroniser plus counter debouncer; rise_o flags the cycle
// before the debounced value goes 0->1 so callers can capture it on that edge.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          differ, flip;

    always_comb begin
        differ = sync_q[1] ^ db_q;
        flip   = differ && (cnt_q == CNT_MAX);
        cnt_d  = (differ && !flip) ? cnt_q + 1'b1 : '0;
        db_d   = flip ? ~db_q : db_q;
        rise_o = flip & ~db_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped switch/key input port: debounced state, sticky W1C key-press
// capture, interrupt enable mask and a registered single-cycle read port.
module mmio_input_port
    import mmio_input_pkg::*;
#(
    parameter int NSW             = 4,
    parameter int NKEY            = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSW-1:0]  sw_raw,
    input  logic [NKEY-1:0] key_raw,
    input  logic            cs,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            rvalid,
    output logic            irq
);

    logic [NSW-1:0]  sw_db;
    logic [NSW-1:0]  sw_rise_unused;
    logic [NKEY-1:0] key_n, key_db, key_rise;
    logic [31:0]     wdata_unused;

    logic [NKEY-1:0] key_edge_q, key_edge_d;
    logic [NKEY-1:0] irq_en_q, irq_en_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            irq_q, irq_d;

    logic            wr_en, rd_en;
    logic [1:0]      idx;
    logic [31:0]     rd_mux;

    // Inverting ahead of the synchroniser is equivalent to inverting after it
    // with key sync flops resetting to 1: both read as "released" out of reset.
    assign key_n        = ~key_raw;
    assign wdata_unused = wdata;

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (sw_raw[g]),
            .db_o   (sw_db[g]),
            .rise_o (sw_rise_unused[g])
        );
    end

    for (genvar g = 0; g < NKEY; g++) begin : g_key
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (key_n[g]),
            .db_o   (key_db[g]),
            .rise_o (key_rise[g])
        );
    end

    always_comb begin
        wr_en = cs & we;
        rd_en = cs & ~we;
        idx   = reg_index(addr);

        // Set after clear so a press landing on a W1C write is not lost.
        key_edge_d = key_edge_q;
        if (wr_en && idx == KEY_EDGE_IDX) key_edge_d = key_edge_d & ~wdata[NKEY-1:0];
        key_edge_d = key_edge_d | key_rise;

        irq_en_d = irq_en_q;
        if (wr_en && idx == IRQ_EN_IDX) irq_en_d = wdata[NKEY-1:0];

        rd_mux = '0;
        case (idx)
            SW_STATE_IDX:  rd_mux[NSW-1:0]  = sw_db;
            KEY_STATE_IDX: rd_mux[NKEY-1:0] = key_db;
            KEY_EDGE_IDX:  rd_mux[NKEY-1:0] = key_edge_q;
            default:       rd_mux[NKEY-1:0] = irq_en_q;
        endcase

        rvalid_d = rd_en;
        rdata_d  = rd_en ? rd_mux : rdata_q;
        irq_d    = |(key_edge_q & irq_en_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_edge_q <= '0;
            irq_en_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            key_edge_q <= key_edge_d;
            irq_en_q   <= irq_en_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            irq_q      <= irq_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_mmio_input_port.sv
// Cycle-by-cycle directed vectors for mmio_input_port with DEBOUNCE_CYCLES=4;
// each record is one clock of inputs plus the outputs expected after that edge.
module tb_mmio_input_port;

    typedef struct {
        logic        rst;
        logic [3:0]  sw;
        logic [3:0]  key;
        logic        cs;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        exp_rvalid;
        logic        chk_data;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sw_raw = 4'h0;
    logic [3:0]  key_raw = 4'hF;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mmio_input_port #(.NSW(4), .NKEY(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .key_raw (key_raw),
        .cs      (cs),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .irq     (irq)
    );

    task automatic add(input logic r, input logic [3:0] s, input logic [3:0] k,
                       input logic c, input logic w, input logic [1:0] a,
                       input logic [31:0] wd, input logic erv, input logic cd,
                       input logic [31:0] ed, input logic eirq);
        vec_t v;
        v.rst = r; v.sw = s; v.key = k; v.cs = c; v.we = w; v.addr = a;
        v.wdata = wd; v.exp_rvalid = erv; v.chk_data = cd; v.exp_rdata = ed;
        v.exp_irq = eirq;
        vecs.push_back(v);
    endtask

    task automatic rd(input logic [3:0] s, input logic [3:0] k, input logic [1:0] a,
                      input logic [31:0] ed, input logic eirq);
        add(1'b0, s, k, 1'b1, 1'b0, a, 32'h0, 1'b1, 1'b1, ed, eirq);
    endtask

    task automatic wr(input logic [3:0] s, input logic [3:0] k, input logic [1:0] a,
                      input logic [31:0] wd, input logic eirq);
        add(1'b0, s, k, 1'b1, 1'b1, a, wd, 1'b0, 1'b0, 32'h0, eirq);
    endtask

    task automatic idle(input logic [3:0] s, input logic [3:0] k, input logic eirq);
        add(1'b0, s, k, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0, eirq);
    endtask

    task automatic check(input int i, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %h, expected %h", i, name, act, exp);
        end
    endtask

    initial begin
        // Reset, then every register reads back 0.
        for (int i = 0; i < 3; i++) add(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        for (int a = 0; a < 4; a++) rd(4'h0, 4'hF, 2'(a), 32'h0, 1'b0);

        // Switch debounce: first sampling edge is the first vector; the 6th edge
        // updates SW_STATE, so only the 7th read sees it.
        for (int i = 0; i < 6; i++) rd(4'h1, 4'hF, 2'd0, 32'h0, 1'b0);
        rd(4'h1, 4'hF, 2'd0, 32'h1, 1'b0);

        // Three-cycle glitch on KEY3 is rejected.
        for (int i = 0; i < 3; i++) rd(4'h1, 4'h7, 2'(1 + i % 2), 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) rd(4'h1, 4'hF, 2'(1 + i % 2), 32'h0, 1'b0);

        // Enable KEY3 interrupt, then a held press.
        wr(4'h1, 4'hF, 2'd3, 32'h8, 1'b0);
        rd(4'h1, 4'hF, 2'd3, 32'h8, 1'b0);
        for (int i = 0; i < 6; i++) rd(4'h1, 4'h7, 2'd1, 32'h0, 1'b0);
        rd(4'h1, 4'h7, 2'd1, 32'h8, 1'b1);
        rd(4'h1, 4'h7, 2'd2, 32'h8, 1'b1);
        idle(4'h1, 4'h7, 1'b1);
        idle(4'h1, 4'h7, 1'b1);

        // Release: state clears after debounce, the captured edge stays.
        for (int i = 0; i < 6; i++) rd(4'h1, 4'hF, 2'd1, 32'h8, 1'b1);
        rd(4'h1, 4'hF, 2'd1, 32'h0, 1'b1);
        rd(4'h1, 4'hF, 2'd2, 32'h8, 1'b1);

        // W1C: irq drops one edge after the clearing write.
        wr(4'h1, 4'hF, 2'd2, 32'h8, 1'b1);
        idle(4'h1, 4'hF, 1'b0);
        rd(4'h1, 4'hF, 2'd2, 32'h0, 1'b0);

        // Re-arm the pending bit with a press, then release it.
        for (int i = 0; i < 6; i++) idle(4'h1, 4'h7, 1'b0);
        rd(4'h1, 4'h7, 2'd2, 32'h8, 1'b1);
        for (int i = 0; i < 6; i++) idle(4'h1, 4'hF, 1'b1);
        rd(4'h1, 4'hF, 2'd1, 32'h0, 1'b1);

        // Collision: W1C on the very edge a new press is captured; set wins.
        for (int i = 0; i < 5; i++) idle(4'h1, 4'h7, 1'b1);
        wr(4'h1, 4'h7, 2'd2, 32'h8, 1'b1);
        rd(4'h1, 4'h7, 2'd2, 32'h8, 1'b1);
        rd(4'h1, 4'h7, 2'd1, 32'h8, 1'b1);

        // Clear it for real and let the key settle released.
        wr(4'h1, 4'hF, 2'd2, 32'h8, 1'b1);
        for (int i = 0; i < 5; i++) idle(4'h1, 4'hF, 1'b0);
        rd(4'h1, 4'hF, 2'd1, 32'h0, 1'b0);

        // Reset two cycles into a press; the press is discarded.
        idle(4'h1, 4'h7, 1'b0);
        idle(4'h1, 4'h7, 1'b0);
        for (int i = 0; i < 2; i++) add(1'b1, 4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) rd(4'h1, 4'hF, 2'(1 + i % 2), 32'h0, 1'b0);

        // Key held through reset is seen as a fresh press; IRQ_EN was reset.
        for (int i = 0; i < 2; i++) add(1'b1, 4'h1, 4'h7, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) idle(4'h1, 4'h7, 1'b0);
        rd(4'h1, 4'h7, 2'd2, 32'h0, 1'b0);
        rd(4'h1, 4'h7, 2'd2, 32'h8, 1'b0);

        // Re-enable, then back-to-back reads of all four registers.
        wr(4'h1, 4'h7, 2'd3, 32'h8, 1'b0);
        rd(4'h1, 4'h7, 2'd0, 32'h1, 1'b1);
        rd(4'h1, 4'h7, 2'd1, 32'h8, 1'b1);
        rd(4'h1, 4'h7, 2'd2, 32'h8, 1'b1);
        rd(4'h1, 4'h7, 2'd3, 32'h8, 1'b1);

        // Write to SW_STATE is ignored and rdata holds while not reading.
        add(1'b0, 4'h1, 4'h7, 1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8, 1'b1);
        rd(4'h1, 4'h7, 2'd0, 32'h1, 1'b1);

        // Masking the enable drops irq one edge later.
        wr(4'h1, 4'h7, 2'd3, 32'h0, 1'b1);
        idle(4'h1, 4'h7, 1'b0);
        rd(4'h1, 4'h7, 2'd3, 32'h0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst     = vecs[i].rst;
            sw_raw  = vecs[i].sw;
            key_raw = vecs[i].key;
            cs      = vecs[i].cs;
            we      = vecs[i].we;
            addr    = vecs[i].addr;
            wdata   = vecs[i].wdata;
            @(posedge clk);
            #1;
            check(i, "rvalid", 32'(rvalid), 32'(vecs[i].exp_rvalid));
            check(i, "irq", 32'(irq), 32'(vecs[i].exp_irq));
            if (vecs[i].chk_data) check(i, "rdata", rdata, vecs[i].exp_rdata);
        end

        @(negedge clk);
        cs = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
